// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and frame constants,
// common to the transmit engine and the receiver path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_engine_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period; a synchronous clear parks it at zero between frames.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = !clear && (cnt_q == LAST);

  // NOTE: sequential state is assigned only with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule : baud_tick_gen

// File: rtl/uart_tx_engine.sv
// FIFO-draining UART transmitter: start bit, 8 data bits LSB-first, stop bit.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ        = 12_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT    = CLK_FREQ / BAUD_RATE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_en,
  input  logic                       fifo_empty,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_r_data,
  output logic                       fifo_re,
  output logic                       tx,
  output logic                       busy,
  output logic                       done
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_engine: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DATA_WIDTH != UART_DATA_BITS) begin : g_bad_width
      $error("uart_tx_engine: FIFO_DATA_WIDTH must equal UART_DATA_BITS");
    end
  endgenerate

  localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_e              state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shift_q;
  logic [UART_BIT_IDX_W-1:0]   bit_idx_q;
  logic                        tick;
  logic                        baud_clear;
  logic                        can_fetch;
`ifdef UART_TX_PARITY_EN
  logic                        parity_q;
`endif

  assign can_fetch  = tx_en && !fifo_empty;
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a value held (latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (can_fetch) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick && (bit_idx_q == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP:  if (tick) state_d = can_fetch ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pops happen only from IDLE or on the last stop cycle; reset masks the
  // strobe so a held tx_en cannot pop a byte while the engine is held off.
  assign fifo_re = rst && can_fetch &&
                   ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick));

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_STOP) && tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (state_q == ST_FETCH) begin
      shift_q   <= fifo_r_data;
      bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if ((state_q == ST_DATA) && tick) begin
      shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
      bit_idx_q <= bit_idx_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_q ^ shift_q[0];
`endif
    end
  end

  // Line level is decoded from registered state and data only; the FIFO
  // read data never reaches tx without passing through shift_q first.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx = parity_q;
`endif
      default:   tx = 1'b1;
    endcase
  end

endmodule : uart_tx_engine
